taxi_axil_rd_arb: RTL

Round-robin arbiter sharing one AXI4-Lite read master port among PORTS requesters, with one transaction in flight at a time. It sits between several read-only control clients (CSR readers, debug bridge, management CPU) and a single downstream AXI4-Lite read path. It sequences AR/R handshakes, routes each R response back to the requester that issued the read, and optionally aborts hung reads with a timeout.

---
 rtl/taxi_axil_arb_pkg.sv | 15 +
 rtl/taxi_axil_if.sv | 36 +++
 rtl/taxi_axil_rd_arb_rr.sv | 25 ++
 rtl/taxi_axil_rd_arb.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/taxi_axil_arb_pkg.sv
// Shared definitions for the AXI4-Lite read/write arbiters.
// Holds the arbiter FSM states and the AXI response codes.
package taxi_axil_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP,
        DRAIN
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/taxi_axil_if.sv
// AXI4-Lite read channel interface.
// Provides read master and read slave modports.
interface taxi_axil_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter bit ARUSER_EN = 1'b0,
    parameter int ARUSER_W  = 1,
    parameter bit RUSER_EN  = 1'b0,
    parameter int RUSER_W   = 1
);
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic [ARUSER_W-1:0] aruser;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic [RUSER_W-1:0]  ruser;
    logic                rvalid;
    logic                rready;

    modport rd_mst (
        output araddr, arprot, aruser, arvalid,
        input  arready,
        input  rdata, rresp, ruser, rvalid,
        output rready
    );

    modport rd_slv (
        input  araddr, arprot, aruser, arvalid,
        output arready,
        output rdata, rresp, ruser, rvalid,
        input  rready
    );

endinterface

// File: rtl/taxi_axil_rd_arb_rr.sv
// Rotating priority encoder: first request after 'last', wrapping.
// Purely combinational; used by the AXI4-Lite read arbiter.
module taxi_axil_rd_arb_rr #(
    parameter int PORTS = 4,
    localparam int CL = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [CL-1:0]    last,
    output logic [CL-1:0]    idx,
    output logic             hit
);

    // Walk from farthest to nearest so the nearest hit is written last
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int k = PORTS; k >= 1; k--) begin
            if (req[(int'(last) + k) % PORTS]) begin
                idx = CL'((int'(last) + k) % PORTS);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/taxi_axil_rd_arb.sv
// Round-robin AXI4-Lite read arbiter, one transaction in flight.
// Define TAXI_AXIL_RD_ARB_TIMEOUT_EN to abort hung reads with SLVERR.
module taxi_axil_rd_arb
    import taxi_axil_arb_pkg::*;
#(
    parameter int PORTS   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    taxi_axil_if.rd_slv              s_axil_rd [PORTS],
    taxi_axil_if.rd_mst              m_axil_rd,
    output logic [$clog2(PORTS)-1:0] grant,
    output logic                     grant_valid
);

    localparam int CL        = $clog2(PORTS);
    localparam int ADDR_W    = m_axil_rd.ADDR_W;
    localparam int DATA_W    = m_axil_rd.DATA_W;
    localparam bit ARUSER_EN = m_axil_rd.ARUSER_EN;
    localparam int ARUSER_W  = m_axil_rd.ARUSER_W;
    localparam bit RUSER_EN  = m_axil_rd.RUSER_EN;
    localparam int RUSER_W   = m_axil_rd.RUSER_W;

    if (PORTS < 2 || PORTS > 16)
        $fatal(0, "PORTS must be within 2..16");

    logic [PORTS-1:0]    req;
    logic [PORTS-1:0]    s_rready;
    logic [ADDR_W-1:0]   s_araddr [PORTS];
    logic [2:0]          s_arprot [PORTS];
    logic [ARUSER_W-1:0] s_aruser [PORTS];

    arb_state_t    state, state_next;
    logic [CL-1:0] grant_next, last, last_next;
    logic          gv_next;
    logic [CL-1:0] rr_idx;
    logic          rr_hit;

    logic              s_rvalid, m_rready, to_hit;
    logic [DATA_W-1:0] rdata_g;
    logic [1:0]        rresp_g;

    taxi_axil_rd_arb_rr #(.PORTS(PORTS)) u_rr (
        .req  (req),
        .last (last),
        .idx  (rr_idx),
        .hit  (rr_hit)
    );

    for (genvar n = 0; n < PORTS; n++) begin : g_port
        if (s_axil_rd[n].DATA_W != DATA_W ||
            s_axil_rd[n].ADDR_W != ADDR_W ||
            s_axil_rd[n].ARUSER_EN != ARUSER_EN ||
            s_axil_rd[n].ARUSER_W != ARUSER_W ||
            s_axil_rd[n].RUSER_EN != RUSER_EN ||
            s_axil_rd[n].RUSER_W != RUSER_W)
            $fatal(0, "Requester interface widths differ from master");

        logic sel;
        logic rsel;
        assign sel  = grant == CL'(n);
        assign rsel = sel && s_rvalid;

        assign req[n]      = s_axil_rd[n].arvalid;
        assign s_rready[n] = s_axil_rd[n].rready;
        assign s_araddr[n] = s_axil_rd[n].araddr;
        assign s_arprot[n] = s_axil_rd[n].arprot;
        assign s_aruser[n] = s_axil_rd[n].aruser;

        assign s_axil_rd[n].arready =
            sel && state == ADDR && m_axil_rd.arready;
        assign s_axil_rd[n].rvalid = rsel;
        assign s_axil_rd[n].rdata  = rsel ? rdata_g : '0;
        assign s_axil_rd[n].rresp  = rsel ? rresp_g : '0;
        if (RUSER_EN) begin : g_ruser
            assign s_axil_rd[n].ruser =
                rsel && !to_hit ? m_axil_rd.ruser : '0;
        end else begin : g_no_ruser
            assign s_axil_rd[n].ruser = '0;
        end
    end

    assign m_axil_rd.arvalid = state == ADDR;
    assign m_axil_rd.araddr  = s_araddr[grant];
    assign m_axil_rd.arprot  = s_arprot[grant];
    if (ARUSER_EN) begin : g_aruser
        assign m_axil_rd.aruser = s_aruser[grant];
    end else begin : g_no_aruser
        assign m_axil_rd.aruser = '0;
    end

`ifdef TAXI_AXIL_RD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic             sat;

    assign sat    = cnt == CNT_W'(TIMEOUT);
    // A real response in the strike cycle takes precedence
    assign to_hit = state == RESP && sat && !m_axil_rd.rvalid;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (state == ADDR)
            cnt <= '0;
        else if (state == RESP && !m_axil_rd.rvalid && !sat)
            cnt <= cnt + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    assign s_rvalid = state == RESP && (m_axil_rd.rvalid || to_hit);
    assign rdata_g  = to_hit ? '0 : m_axil_rd.rdata;
    assign rresp_g  = to_hit ? RESP_SLVERR : m_axil_rd.rresp;
    assign m_rready = (state == RESP && s_rready[grant] && !to_hit) ||
                      state == DRAIN;
    assign m_axil_rd.rready = m_rready;

    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last;
        gv_next    = grant_valid;
        unique case (state)
            IDLE: begin
                if (rr_hit) begin
                    grant_next = rr_idx;
                    gv_next    = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (m_axil_rd.arready)
                    state_next = RESP;
            end
            RESP: begin
                if (m_axil_rd.rvalid && m_rready) begin
                    last_next  = grant;
                    gv_next    = 1'b0;
                    state_next = IDLE;
                end else if (to_hit && s_rready[grant]) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
`ifdef TAXI_AXIL_RD_ARB_TIMEOUT_EN
                if (m_axil_rd.rvalid) begin
                    last_next  = grant;
                    gv_next    = 1'b0;
                    state_next = IDLE;
                end
`else
                gv_next    = 1'b0;
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            last        <= CL'(PORTS - 1);
            grant_valid <= 1'b0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            last        <= last_next;
            grant_valid <= gv_next;
        end
    end

endmodule
